pixel_abs_diff: RTL and testbench
=================================

Name: pixel_abs_diff

Overview:
- Downstream consumer of the delay line: pairs the live pixel stream (in_a) with its DELAY-shifted copy (in_b) and emits the per-pixel absolute difference, e.g. for temporal or row-offset differencing.
- Each input is buffered in a small FIFO, so the two streams may arrive with bounded skew.
- Coordinate alignment between the paired samples is checked and reported.

Parameters:
- WIDTH, 100, image width in pixels; sets frame_done_o and the col wrap check.
- HEIGHT, 100, image height in pixels.
- FIFO_DEPTH, 8, entries per input FIFO; power of two, >= 2.
- CHECK_COORDS, 1, 1 = compare in_a/in_b row/col on every pop; 0 = mismatch logic disabled (outputs held 0).

Ports:
- in_a.clk  input  1  sole clock; in_b.clk and out.clk are tied to the same net.
- rst_n_i  input  1  reset, asynchronous assert, active-low, synchronous deassert.
- in_a  pixel_data_interface.writer  -  live stream: valid, pixel[FP_M+FP_N+FP_S], row[16], col[16].
- in_b  pixel_data_interface.writer  -  delayed stream (delay_line out); same FP_M/FP_N/FP_S as in_a.
- out  pixel_data_interface.reader  -  difference stream; row/col taken from in_a.
- clear_i  input  1  synchronous clear of mismatch_o, overflow_o and mismatch_count_o.
- mismatch_o  output  1  sticky: a popped pair had unequal row or col.
- overflow_o  output  1  sticky: a sample was dropped because its FIFO was full.
- mismatch_count_o  output  16  number of mismatched pairs; saturates at 16'hFFFF.
- frame_done_o  output  1  one-cycle pulse with the out beat at row=HEIGHT-1, col=WIDTH-1.

Behaviour:
- Reset (async, rst_n_i=0):
  - Both FIFOs emptied.
  - out.valid=0, out.pixel=0, out.row=0, out.col=0.
  - mismatch_o=0, overflow_o=0, mismatch_count_o=0, frame_done_o=0.
  - Reset mid-frame discards all buffered samples; no partial output after release.
- Push:
  - On each edge with in_x.valid=1, {pixel,row,col} is written to FIFO_x.
  - No backpressure: the inputs have no ready signal.
- Pop:
  - In any cycle where both FIFO counts (registered) are nonzero, pop one entry from each.
  - Pops are strictly pairwise; never one-sided.
- Latency:
  - Pair popped at edge T appears registered on out at edge T+1.
  - Simultaneous in_a/in_b valid at edge T0 gives out.valid=1 after edge T0+2.
  - Throughput is one pair per clock.
- Push and pop on the same FIFO in the same cycle: legal, count unchanged; this includes the full FIFO case, which does not overflow.
- Overflow:
  - Push to a full FIFO with no pop that cycle: sample dropped, overflow_o set.
  - Stream pairing is not re-synchronised; the mismatch check is expected to flag the result.
- Arithmetic (D = FP_M+FP_N+FP_S):
  - Compute a-b in D+1 bits, signed if FP_S=1, else unsigned; take the magnitude.
  - FP_S=0: the result always fits in D bits.
  - FP_S=1: result sign bit forced 0; magnitudes above 2^(FP_M+FP_N)-1 saturate to that value.
- Coordinate check, on each pop when CHECK_COORDS=1:
  - If row_a!=row_b or col_a!=col_b: mismatch_o set, mismatch_count_o += 1 (saturating).
  - The out beat is still produced.
- frame_done_o: asserted in the same cycle as out.valid when out.row==HEIGHT-1 and out.col==WIDTH-1; 0 otherwise.
- clear_i:
  - Clears the sticky flags and counter at the next edge.
  - If a new mismatch or overflow event coincides with clear_i, the event wins: the flag stays 1 and the count becomes 1.
- No combinational path from any input to any output.

Test Plan:
- FP_M=8,FP_N=0,FP_S=0; in_a and in_b valid together with a=200, b=50, row=3, col=7 -> out.valid 2 cycles later, pixel=150, row=3, col=7; flags 0.
- FP_S=1,FP_M=7,FP_N=0 (D=8): a=+127, b=-128 -> out.pixel=8'h7F (saturated); a=-5, b=+3 -> 8.
- in_b lags in_a by 5 cycles over a full 4x3 frame (WIDTH=4,HEIGHT=3) -> 12 output beats in raster order; frame_done_o pulses once, on row=2,col=3; no flags.
- in_b held idle while in_a sends 9 beats (FIFO_DEPTH=8) -> overflow_o=1 after the 9th; then 8 b-beats give 8 outputs; clear_i -> overflow_o=0.
- in_b col offset by 1 for 3 pairs -> mismatch_o=1, mismatch_count_o=3, 3 outputs still produced; clear_i asserted with a 4th mismatch -> count=1, mismatch_o=1.
- rst_n_i pulsed low mid-frame with 4 entries buffered -> outputs 0 immediately, without waiting for a clock edge; after release, no stale beat emitted; next aligned pair gives out 2 cycles later.

Source files
------------

// File: rtl/pixel_abs_diff_if.sv
// Pixel stream bundle: one beat per clock when valid, with raster coordinates.
// Pixel width is FP_M integer + FP_N fraction + FP_S sign bits.
interface pixel_data_interface #(
  parameter int FP_M = 8,
  parameter int FP_N = 0,
  parameter int FP_S = 0
) (
  input logic clk
);
  localparam int D = FP_M + FP_N + FP_S;

  logic         valid;
  logic [D-1:0] pixel;
  logic [15:0]  row;
  logic [15:0]  col;

  modport writer (input clk, input valid, input pixel, input row, input col);
  modport reader (input clk, output valid, output pixel, output row, output col);
endinterface

// File: rtl/pixel_abs_diff.sv
// Pairs a live pixel stream with its delayed copy through two skew FIFOs and
// emits |a-b| per pair, with sticky coordinate-mismatch and overflow reporting.
module pixel_abs_diff #(
  parameter int WIDTH        = 100,
  parameter int HEIGHT       = 100,
  parameter int FIFO_DEPTH   = 8,
  parameter int CHECK_COORDS = 1
) (
  pixel_data_interface.writer in_a,
  pixel_data_interface.writer in_b,
  pixel_data_interface.reader out,
  input  logic        rst_n_i,
  input  logic        clear_i,
  output logic        mismatch_o,
  output logic        overflow_o,
  output logic [15:0] mismatch_count_o,
  output logic        frame_done_o
);
  localparam int FP_M = in_a.FP_M;
  localparam int FP_N = in_a.FP_N;
  localparam int FP_S = in_a.FP_S;
  localparam int D    = FP_M + FP_N + FP_S;
  localparam int E    = D + 32;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0] LAST_COL = 16'(WIDTH - 1);
  localparam bit          CHK      = (CHECK_COORDS != 0);

  logic clk;
  assign clk = in_a.clk;

  logic [E-1:0]  wdata [2];
  logic [E-1:0]  mem [2][FIFO_DEPTH];
  logic [AW-1:0] wr_ptr [2];
  logic [AW-1:0] rd_ptr [2];
  logic [AW:0]   cnt [2];
  logic [1:0]    push, full, accept;
  logic          pop, ov_event;

  always_comb begin
    wdata[0] = {in_a.pixel, in_a.row, in_a.col};
    wdata[1] = {in_b.pixel, in_b.row, in_b.col};
    push     = {in_b.valid, in_a.valid};
    pop      = (cnt[0] != '0) && (cnt[1] != '0);
    full     = '0;
    accept   = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      full[i]   = (cnt[i] == FULL_CNT);
      // a pop in the same cycle frees the slot, so a full FIFO still accepts
      accept[i] = push[i] && (!full[i] || pop);
    end
    ov_event = |(push & ~accept);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (accept[i]) mem[i][wr_ptr[i]] <= wdata[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (accept[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop)       rd_ptr[i] <= rd_ptr[i] + 1'b1;
        cnt[i] <= cnt[i] + (AW+1)'(accept[i]) - (AW+1)'(pop);
      end
    end
  end

  logic         st_valid;
  logic [E-1:0] st_a, st_b;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_valid <= 1'b0;
      st_a     <= '0;
      st_b     <= '0;
    end else begin
      st_valid <= pop;
      if (pop) begin
        st_a <= mem[0][rd_ptr[0]];
        st_b <= mem[1][rd_ptr[1]];
      end
    end
  end

  logic [D-1:0] a_pix, b_pix, res;
  logic [15:0]  a_row, a_col, b_row, b_col;
  logic [D:0]   diff;

  assign a_pix = st_a[E-1 -: D];
  assign a_row = st_a[31:16];
  assign a_col = st_a[15:0];
  assign b_pix = st_b[E-1 -: D];
  assign b_row = st_b[31:16];
  assign b_col = st_b[15:0];

  generate
    if (FP_S != 0) begin : g_signed
      localparam logic [D:0] SAT = {2'b00, {(D-1){1'b1}}};
      logic [D:0] mag;
      always_comb begin
        diff = {a_pix[D-1], a_pix} - {b_pix[D-1], b_pix};
        mag  = diff[D] ? -diff : diff;
        res  = (mag > SAT) ? SAT[D-1:0] : mag[D-1:0];
      end
    end else begin : g_unsigned
      always_comb begin
        diff = {1'b0, a_pix} - {1'b0, b_pix};
        res  = diff[D] ? D'(-diff) : diff[D-1:0];
      end
    end
  endgenerate

  logic mm_event;
  assign mm_event = CHK && st_valid && ((a_row != b_row) || (a_col != b_col));

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out.valid        <= 1'b0;
      out.pixel        <= '0;
      out.row          <= '0;
      out.col          <= '0;
      frame_done_o     <= 1'b0;
      mismatch_o       <= 1'b0;
      mismatch_count_o <= '0;
      overflow_o       <= 1'b0;
    end else begin
      out.valid    <= st_valid;
      frame_done_o <= st_valid && (a_row == LAST_ROW) && (a_col == LAST_COL);
      if (st_valid) begin
        out.pixel <= res;
        out.row   <= a_row;
        out.col   <= a_col;
      end
      // a coinciding event beats clear_i: flag stays set, count restarts at 1
      if (mm_event) begin
        mismatch_o       <= 1'b1;
        mismatch_count_o <= clear_i ? 16'd1 :
                            (&mismatch_count_o) ? mismatch_count_o : mismatch_count_o + 16'd1;
      end else if (clear_i) begin
        mismatch_o       <= 1'b0;
        mismatch_count_o <= '0;
      end
      if (ov_event)     overflow_o <= 1'b1;
      else if (clear_i) overflow_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pixel_abs_diff.sv
// Bench for pixel_abs_diff: queue-based reference model on an unsigned 4x3
// instance, table vectors on both an unsigned and a signed instance.
module tb_pixel_abs_diff;
  localparam int W = 4;
  localparam int H = 3;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  pixel_data_interface #(.FP_M(8), .FP_N(0), .FP_S(0)) ua (.clk(clk));
  pixel_data_interface #(.FP_M(8), .FP_N(0), .FP_S(0)) ub (.clk(clk));
  pixel_data_interface #(.FP_M(8), .FP_N(0), .FP_S(0)) uo (.clk(clk));
  pixel_data_interface #(.FP_M(7), .FP_N(0), .FP_S(1)) sa (.clk(clk));
  pixel_data_interface #(.FP_M(7), .FP_N(0), .FP_S(1)) sb (.clk(clk));
  pixel_data_interface #(.FP_M(7), .FP_N(0), .FP_S(1)) so (.clk(clk));

  logic u_mm, u_ov, u_fd, s_mm, s_ov, s_fd;
  logic [15:0] u_cnt, s_cnt;

  pixel_abs_diff #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(DEPTH), .CHECK_COORDS(1)) u_dut (
    .in_a(ua), .in_b(ub), .out(uo), .rst_n_i(rst_n), .clear_i(clear),
    .mismatch_o(u_mm), .overflow_o(u_ov), .mismatch_count_o(u_cnt), .frame_done_o(u_fd));

  pixel_abs_diff #(.FIFO_DEPTH(DEPTH)) s_dut (
    .in_a(sa), .in_b(sb), .out(so), .rst_n_i(rst_n), .clear_i(clear),
    .mismatch_o(s_mm), .overflow_o(s_ov), .mismatch_count_o(s_cnt), .frame_done_o(s_fd));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int v, input int p, input int r, input int c);
    ua.valid = v[0]; ua.pixel = 8'(p); ua.row = 16'(r); ua.col = 16'(c);
  endtask
  task automatic set_b(input int v, input int p, input int r, input int c);
    ub.valid = v[0]; ub.pixel = 8'(p); ub.row = 16'(r); ub.col = 16'(c);
  endtask
  task automatic set_s(input int v, input int pa, input int pb);
    sa.valid = v[0]; sa.pixel = 8'(pa); sa.row = 16'd3; sa.col = 16'd7;
    sb.valid = v[0]; sb.pixel = 8'(pb); sb.row = 16'd3; sb.col = 16'd7;
  endtask
  task automatic idle();
    set_a(0, 0, 0, 0);
    set_b(0, 0, 0, 0);
    set_s(0, 0, 0);
  endtask

  // Reference model for u_dut: two queues, one-cycle pop-to-output pending pair.
  typedef struct { logic [7:0] pix; logic [15:0] row; logic [15:0] col; } beat_t;
  beat_t qa[$], qb[$];
  beat_t st_a, st_b;
  bit st_v = 1'b0;
  int e_valid = 0, e_pix = 0, e_row = 0, e_col = 0, e_fd = 0, e_mm = 0, e_ov = 0, e_cnt = 0;

  always @(posedge clk) begin
    bit pop, mm_ev, ov_ev;
    int d;
    if (!rst_n) begin
      qa.delete(); qb.delete();
      st_v = 1'b0;
      e_valid = 0; e_pix = 0; e_row = 0; e_col = 0;
      e_fd = 0; e_mm = 0; e_ov = 0; e_cnt = 0;
    end else begin
      mm_ev = 1'b0;
      e_valid = int'(st_v);
      e_fd = 0;
      if (st_v) begin
        d = int'(st_a.pix) - int'(st_b.pix);
        e_pix = (d < 0) ? -d : d;
        e_row = int'(st_a.row);
        e_col = int'(st_a.col);
        e_fd  = int'((e_row == H - 1) && (e_col == W - 1));
        mm_ev = (st_a.row != st_b.row) || (st_a.col != st_b.col);
      end
      if (mm_ev) begin
        e_mm = 1;
        e_cnt = clear ? 1 : ((e_cnt >= 65535) ? 65535 : e_cnt + 1);
      end else if (clear) begin
        e_mm = 0;
        e_cnt = 0;
      end
      pop = (qa.size() > 0) && (qb.size() > 0);
      st_v = pop;
      if (pop) begin
        st_a = qa.pop_front();
        st_b = qb.pop_front();
      end
      ov_ev = 1'b0;
      if (ua.valid) begin
        if (qa.size() < DEPTH) qa.push_back('{ua.pixel, ua.row, ua.col});
        else ov_ev = 1'b1;
      end
      if (ub.valid) begin
        if (qb.size() < DEPTH) qb.push_back('{ub.pixel, ub.row, ub.col});
        else ov_ev = 1'b1;
      end
      if (ov_ev) e_ov = 1;
      else if (clear) e_ov = 0;
    end
    #2;
    chk("mdl_valid", 32'(uo.valid), e_valid);
    if (e_valid != 0) begin
      chk("mdl_pixel", 32'(uo.pixel), e_pix);
      chk("mdl_row", 32'(uo.row), e_row);
      chk("mdl_col", 32'(uo.col), e_col);
    end
    chk("mdl_frame_done", 32'(u_fd), e_fd);
    chk("mdl_mismatch", 32'(u_mm), e_mm);
    chk("mdl_overflow", 32'(u_ov), e_ov);
    chk("mdl_count", 32'(u_cnt), e_cnt);
  end

  typedef struct { bit sgn; int a; int b; int exp; } vec_t;
  vec_t vecs[10];

  initial begin
    int beats, fds, fd_row, fd_col, ia, ib;
    int pa[48], pb[48];

    vecs[0] = '{1'b0, 200, 50, 150};
    vecs[1] = '{1'b0, 50, 200, 150};
    vecs[2] = '{1'b0, 0, 255, 255};
    vecs[3] = '{1'b0, 7, 7, 0};
    vecs[4] = '{1'b1, 8'h7F, 8'h80, 8'h7F};
    vecs[5] = '{1'b1, 8'hFB, 8'h03, 8};
    vecs[6] = '{1'b1, 8'h80, 8'h7F, 8'h7F};
    vecs[7] = '{1'b1, 8'h80, 8'h80, 0};
    vecs[8] = '{1'b1, 8'hFF, 8'h01, 2};
    vecs[9] = '{1'b1, 8'h10, 8'hF0, 32};

    idle();
    rst_n = 1'b0;
    step(); step();
    chk("rst_valid", 32'(uo.valid), 0);
    chk("rst_pixel", 32'(uo.pixel), 0);
    chk("rst_rowcol", 32'({uo.row, uo.col}), 0);
    chk("rst_flags", 32'({u_mm, u_ov, u_fd}), 0);
    chk("rst_count", 32'(u_cnt), 0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].sgn) set_s(1, vecs[i].a, vecs[i].b);
      else begin
        set_a(1, vecs[i].a, 3, 7);
        set_b(1, vecs[i].b, 3, 7);
      end
      step();
      idle();
      step();
      chk($sformatf("vec%0d_early", i), 32'(vecs[i].sgn ? so.valid : uo.valid), 0);
      step();
      if (vecs[i].sgn) begin
        chk($sformatf("vec%0d_valid", i), 32'(so.valid), 1);
        chk($sformatf("vec%0d_pixel", i), 32'(so.pixel), vecs[i].exp);
        chk($sformatf("vec%0d_sflags", i), 32'({s_mm, s_ov, s_fd}), 0);
      end else begin
        chk($sformatf("vec%0d_valid", i), 32'(uo.valid), 1);
        chk($sformatf("vec%0d_pixel", i), 32'(uo.pixel), vecs[i].exp);
        chk($sformatf("vec%0d_rowcol", i), 32'({uo.row, uo.col}), {16'd3, 16'd7});
        chk($sformatf("vec%0d_flags", i), 32'({u_mm, u_ov, u_fd}), 0);
      end
    end

    // in_b lags in_a by 5 cycles over one 4x3 frame
    beats = 0; fds = 0; fd_row = -1; fd_col = -1;
    for (int c = 0; c < 25; c++) begin
      if (c < 12) set_a(1, 17 * c, c / W, c % W); else set_a(0, 0, 0, 0);
      if (c >= 5 && c < 17) set_b(1, 5 * c, (c - 5) / W, (c - 5) % W); else set_b(0, 0, 0, 0);
      step();
      if (uo.valid) beats++;
      if (u_fd) begin fds++; fd_row = int'(uo.row); fd_col = int'(uo.col); end
    end
    chk("lag_beats", beats, 12);
    chk("lag_fd_pulses", fds, 1);
    chk("lag_fd_pos", 32'({fd_row[15:0], fd_col[15:0]}), {16'd2, 16'd3});
    chk("lag_flags", 32'({u_mm, u_ov}), 0);

    // overflow: 9 a-beats with b idle, then 8 matching b-beats
    for (int i = 0; i < 9; i++) begin
      set_a(1, 100 + i, 1, i);
      step();
      if (i == 7) chk("ovf_before", 32'(u_ov), 0);
    end
    idle();
    chk("ovf_after9", 32'(u_ov), 1);
    beats = 0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) set_b(1, 90, 1, i); else set_b(0, 0, 0, 0);
      step();
      if (uo.valid) beats++;
    end
    chk("ovf_beats", beats, 8);
    clear = 1'b1; step(); clear = 1'b0;
    chk("ovf_cleared", 32'(u_ov), 0);

    // column offset by one on three pairs
    beats = 0;
    for (int i = 0; i < 7; i++) begin
      if (i < 3) begin set_a(1, 40, 0, i); set_b(1, 10, 0, i + 1); end else idle();
      step();
      if (uo.valid) beats++;
    end
    chk("mm_beats", beats, 3);
    chk("mm_flag", 32'(u_mm), 1);
    chk("mm_count3", 32'(u_cnt), 3);
    set_a(1, 1, 2, 0); set_b(1, 2, 2, 1);
    step();
    idle();
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("mm_clear_race_cnt", 32'(u_cnt), 1);
    chk("mm_clear_race_flag", 32'(u_mm), 1);
    clear = 1'b1; step(); clear = 1'b0;
    chk("mm_cleared", 32'({u_mm, u_cnt}), 0);

    // async reset mid-frame with four a-entries buffered
    for (int i = 0; i < 3; i++) begin set_a(1, 10 + i, 0, i); step(); end
    set_a(1, 13, 0, 3); set_b(1, 30, 5, 5); step();
    set_b(0, 0, 0, 0); set_a(1, 14, 1, 0); step();
    idle(); step();
    chk("pre_rst_valid", 32'(uo.valid), 1);
    chk("pre_rst_pixel", 32'(uo.pixel), 20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(uo.valid), 0);
    chk("arst_pixel", 32'(uo.pixel), 0);
    chk("arst_flags", 32'({u_mm, u_ov, u_fd}), 0);
    chk("arst_count", 32'(u_cnt), 0);
    step();
    rst_n = 1'b1;
    beats = 0;
    for (int i = 0; i < 5; i++) begin step(); if (uo.valid) beats++; end
    chk("post_rst_stale", beats, 0);
    set_a(1, 60, 1, 1); set_b(1, 40, 1, 1);
    step();
    idle();
    step();
    chk("post_rst_early", 32'(uo.valid), 0);
    step();
    chk("post_rst_valid", 32'(uo.valid), 1);
    chk("post_rst_pixel", 32'(uo.pixel), 20);

    // randomized skewed streams, four full frames
    for (int i = 0; i < 48; i++) begin
      pa[i] = int'($urandom_range(0, 255));
      pb[i] = int'($urandom_range(0, 255));
    end
    ia = 0; ib = 0; beats = 0; fds = 0;
    for (int cyc = 0; cyc < 600 && ib < 48; cyc++) begin
      if (ia < 48 && (ia - ib) < 6 && $urandom_range(0, 1) == 1) begin
        set_a(1, pa[ia], (ia / W) % H, ia % W);
        ia++;
      end else set_a(0, 0, 0, 0);
      if (ib < ia && $urandom_range(0, 2) != 0) begin
        set_b(1, pb[ib], (ib / W) % H, ib % W);
        ib++;
      end else set_b(0, 0, 0, 0);
      step();
      if (uo.valid) beats++;
      if (u_fd) fds++;
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      step();
      if (uo.valid) beats++;
      if (u_fd) fds++;
    end
    chk("rand_beats", beats, 48);
    chk("rand_fd", fds, 4);
    chk("rand_flags", 32'({u_mm, u_ov}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
